dbus_tx: RTL

DBUS_TX -- requirements
Module: dbus_tx

---
 rtl/dbus_tx.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/dbus_tx.sv
// -----------------------------------------------------------------------------
// dbus_tx -- two-wire (tip/ring) open-drain byte transmitter.
//
// Pops bytes from a show-ahead source FIFO and sends them LSB first over a
// wired-AND tip/ring pair. Each bit is a four-phase exchange with the receiver:
//   1. both lines idle high
//   2. sender pulls one line low (bit 0 -> tip, bit 1 -> ring)
//   3. receiver acknowledges by pulling the opposite line low
//   4. sender releases its line and waits for both lines to float high again
//
// FIFO handshake: o_readen is a pop strobe. When it is high, i_data is
// captured on that same rising edge and the FIFO advances its head on that
// edge. It is only raised in IDLE with i_empty low, and the FSM leaves IDLE on
// the same edge, so a pop is always a single cycle.
//
// Optional feature (macro DBUS_TX_TIMEOUT_EN): a per-state timeout counter
// aborts a byte that spends c_TIMEOUTCYCLES clocks in any wait state, releases
// the lines and pulses o_timeout. With the macro undefined the wait states
// wait forever and o_timeout is tied low.
//
// Ports:
//   i_clock     sole clock, rising edge
//   i_reset     asynchronous, active-high reset
//   i_empty     source FIFO empty flag
//   i_data      source FIFO head byte
//   o_readen    FIFO pop strobe
//   i_tip       raw tip line level (asynchronous)
//   i_ring      raw ring line level (asynchronous)
//   o_tip_low   1 = pull tip low
//   o_ring_low  1 = pull ring low
//   o_busy      byte in progress (every state except IDLE)
//   o_timeout   one-cycle pulse when a byte is aborted by the timeout
// -----------------------------------------------------------------------------
module dbus_tx #(
  parameter int c_DATAWIDTH     = 8,
  parameter int c_TIMEOUTCYCLES = 1200000,
  parameter int c_TIMEOUTWIDTH  = 21
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_empty,
  input  logic [c_DATAWIDTH-1:0] i_data,
  output logic                   o_readen,
  input  logic                   i_tip,
  input  logic                   i_ring,
  output logic                   o_tip_low,
  output logic                   o_ring_low,
  output logic                   o_busy,
  output logic                   o_timeout
);

  localparam int c_CNTWIDTH = (c_DATAWIDTH > 1) ? $clog2(c_DATAWIDTH) : 1;
  localparam logic [c_CNTWIDTH-1:0] c_LASTBIT = c_CNTWIDTH'(c_DATAWIDTH - 1);

  // The timeout counter must be able to represent c_TIMEOUTCYCLES.
  if ((c_TIMEOUTCYCLES >> c_TIMEOUTWIDTH) != 0) begin : g_bad_timeout_width
    $error("dbus_tx: c_TIMEOUTWIDTH too small for c_TIMEOUTCYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAITIDLE = 3'd1,
    S_DRIVE    = 3'd2,
    S_WAITACK  = 3'd3,
    S_RELEASE  = 3'd4,
    S_WAITREL  = 3'd5
  } state_t;

  state_t                  state_q;
  logic [c_DATAWIDTH-1:0]  shift_q;
  logic [c_CNTWIDTH-1:0]   bitcnt_q;
  logic                    tip_low_q;
  logic                    ring_low_q;

  // Two-flop synchronizers; idle level of the lines is high.
  logic tip_meta_q, tip_sync_q;
  logic ring_meta_q, ring_sync_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tip_meta_q  <= 1'b1;
      tip_sync_q  <= 1'b1;
      ring_meta_q <= 1'b1;
      ring_sync_q <= 1'b1;
    end else begin
      tip_meta_q  <= i_tip;
      tip_sync_q  <= tip_meta_q;
      ring_meta_q <= i_ring;
      ring_sync_q <= ring_meta_q;
    end
  end

  logic                   lines_high;
  logic                   ack_seen;
  logic                   is_wait;
  logic                   wait_done;
  logic [c_DATAWIDTH-1:0] shift_nxt;

  assign lines_high = tip_sync_q & ring_sync_q;
  // The receiver acknowledges on the line we are not driving.
  assign ack_seen   = ring_low_q ? ~tip_sync_q : ~ring_sync_q;
  assign shift_nxt  = shift_q >> 1;

  always_comb begin
    is_wait   = 1'b0;
    wait_done = 1'b0;
    case (state_q)
      S_WAITIDLE: begin is_wait = 1'b1; wait_done = lines_high; end
      S_WAITACK:  begin is_wait = 1'b1; wait_done = ack_seen;   end
      S_WAITREL:  begin is_wait = 1'b1; wait_done = lines_high; end
      default:    begin is_wait = 1'b0; wait_done = 1'b0;       end
    endcase
  end

`ifdef DBUS_TX_TIMEOUT_EN
  logic [c_TIMEOUTWIDTH-1:0] tmo_q;
  logic                      tmo_hit;
  logic                      timeout_q;

  // Every wait state is entered from a one-cycle (or IDLE) state where the
  // counter sits at zero, so clearing outside "waiting and not done" restarts
  // the count on each state entry.
  assign tmo_hit = is_wait & ~wait_done &
                   (tmo_q == c_TIMEOUTWIDTH'(c_TIMEOUTCYCLES - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tmo_q <= '0;
    end else if (is_wait && !wait_done && !tmo_hit) begin
      tmo_q <= tmo_q + c_TIMEOUTWIDTH'(1);
    end else begin
      tmo_q <= '0;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Main FSM. Drive flops are loaded on the edge that enters DRIVE so the
  // line is pulled during DRIVE itself.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      tip_low_q  <= 1'b0;
      ring_low_q <= 1'b0;
`ifdef DBUS_TX_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef DBUS_TX_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!i_empty) begin
            shift_q  <= i_data;
            bitcnt_q <= '0;
            state_q  <= S_WAITIDLE;
          end
        end
        S_WAITIDLE: begin
          if (lines_high) begin
            tip_low_q  <= ~shift_q[0];
            ring_low_q <= shift_q[0];
            state_q    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          state_q <= S_WAITACK;
        end
        S_WAITACK: begin
          if (ack_seen) begin
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          tip_low_q  <= 1'b0;
          ring_low_q <= 1'b0;
          state_q    <= S_WAITREL;
        end
        S_WAITREL: begin
          if (lines_high) begin
            shift_q <= shift_nxt;
            if (bitcnt_q == c_LASTBIT) begin
              bitcnt_q <= '0;
              state_q  <= S_IDLE;
            end else begin
              bitcnt_q   <= bitcnt_q + c_CNTWIDTH'(1);
              tip_low_q  <= ~shift_nxt[0];
              ring_low_q <= shift_nxt[0];
              state_q    <= S_DRIVE;
            end
          end
        end
        default: begin
          tip_low_q  <= 1'b0;
          ring_low_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
`ifdef DBUS_TX_TIMEOUT_EN
      // Abort overrides whatever the wait state would have done.
      if (tmo_hit) begin
        tip_low_q  <= 1'b0;
        ring_low_q <= 1'b0;
        shift_q    <= '0;
        bitcnt_q   <= '0;
        timeout_q  <= 1'b1;
        state_q    <= S_IDLE;
      end
`endif
    end
  end

  // Gated by i_reset so a pending FIFO cannot be popped while reset is held.
  assign o_readen   = (state_q == S_IDLE) & ~i_empty & ~i_reset;
  assign o_busy     = (state_q != S_IDLE);
  assign o_tip_low  = tip_low_q;
  assign o_ring_low = ring_low_q;

endmodule
